// File: rtl/jt9346_master.sv
// rtl/jt9346_master.sv - host-side serial command controller for a 93C46-style x16 EEPROM
//
// Takes one parallel command at a time and turns it into a chip-select,
// serial-clock and data-in frame. For reads it shifts in a 16-bit word from sdo.
// For write/erase commands it polls the ready status after the frame.
// Completion is reported with a single-cycle response.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only while idle)
//   cmd_op[2:0]                0 READ 1 WRITE 2 ERASE 3 EWEN 4 EWDS 5 ERAL 6 WRAL 7 reserved
//   cmd_addr[5:0]              word address
//   cmd_data[15:0]             write data
//   rsp_valid                  one-cycle completion pulse
//   rsp_data[15:0], rsp_err    response payload, qualified by rsp_valid
//   scs, sclk, sdi             serial pins to the EEPROM
//   sdo                        serial data / ready status from the EEPROM
module jt9346_master #(
    parameter int CLKDIV  = 4,
    parameter int SDO_DLY = 2,
    parameter int TCS     = 4,
    parameter int TMO     = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [5:0]  cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        scs,
    output logic        sclk,
    output logic        sdi,
    input  logic        sdo
);

    // One counter serves the sclk phases, the chip-select gap and the poll window.
    localparam int CMAX = (TMO > TCS) ? ((TMO > CLKDIV) ? TMO : CLKDIV)
                                      : ((TCS > CLKDIV) ? TCS : CLKDIV);
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] CLKDIV_C = CW'(CLKDIV);
    localparam logic [CW-1:0] SDO_C    = CW'(SDO_DLY);
    localparam logic [CW-1:0] TCS_C    = CW'(TCS);
    localparam logic [CW-1:0] TMO_C    = CW'(TMO);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    localparam logic [2:0] OP_READ  = 3'd0;
    localparam logic [2:0] OP_WRITE = 3'd1;
    localparam logic [2:0] OP_ERASE = 3'd2;
    localparam logic [2:0] OP_EWEN  = 3'd3;
    localparam logic [2:0] OP_EWDS  = 3'd4;
    localparam logic [2:0] OP_ERAL  = 3'd5;
    localparam logic [2:0] OP_WRAL  = 3'd6;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_GAP,
        S_POLL,
        S_FIN,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  op_q, op_d;
    logic [24:0] frame_q, frame_d;
    logic [4:0]  bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] rx_q, rx_d;
    logic        err_q, err_d;
    logic        cmd_ready_q, cmd_ready_d;
    logic        scs_q, scs_d;
    logic        sclk_q, sclk_d;
    logic        sdi_q, sdi_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;

    logic [7:0]  new_hdr;
    logic [24:0] new_frame;
    logic [4:0]  last_bit;
    logic        needs_poll;

    // Opcode and address field of the frame being accepted.
    always_comb begin
        new_hdr = 8'h00;
        case (cmd_op)
            OP_READ:  new_hdr = {2'b10, cmd_addr};
            OP_WRITE: new_hdr = {2'b01, cmd_addr};
            OP_ERASE: new_hdr = {2'b11, cmd_addr};
            OP_EWEN:  new_hdr = 8'b00_110000;
            OP_EWDS:  new_hdr = 8'b00_000000;
            OP_ERAL:  new_hdr = 8'b00_100000;
            OP_WRAL:  new_hdr = 8'b00_010000;
            default:  new_hdr = 8'h00;
        endcase
        // Read frames carry 16 trailing zeros while the EEPROM drives data out.
        new_frame = {1'b1, new_hdr,
                     ((cmd_op == OP_WRITE) || (cmd_op == OP_WRAL)) ? cmd_data : 16'h0000};
    end

    assign last_bit   = ((op_q == OP_READ) || (op_q == OP_WRITE) || (op_q == OP_WRAL))
                        ? 5'd24 : 5'd8;
    assign needs_poll = (op_q == OP_WRITE) || (op_q == OP_ERASE) ||
                        (op_q == OP_ERAL)  || (op_q == OP_WRAL);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        frame_d     = frame_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        err_d       = err_q;
        cmd_ready_d = cmd_ready_q;
        scs_d       = scs_q;
        sclk_d      = sclk_q;
        sdi_d       = sdi_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 16'h0000;
        rsp_err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    cmd_ready_d = 1'b0;
                    op_d        = cmd_op;
                    if (cmd_op == 3'd7) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        err_d   = 1'b0;
                        frame_d = new_frame;
                        bit_d   = 5'd0;
                        cnt_d   = ONE_C;
                        rx_d    = 16'h0000;
                        scs_d   = 1'b1;
                        sclk_d  = 1'b0;
                        sdi_d   = new_frame[24];
                        state_d = S_SHIFT;
                    end
                end
            end

            S_SHIFT: begin
                // cnt_q counts clk edges since the current phase began (1-based),
                // so cnt_q == SDO_C during a high phase is SDO_DLY after the rise.
                if (sclk_q && (cnt_q == SDO_C) && (op_q == OP_READ) && (bit_q >= 5'd9)) begin
                    rx_d = {rx_q[14:0], sdo};
                end
                if (cnt_q == CLKDIV_C) begin
                    cnt_d = ONE_C;
                    if (!sclk_q) begin
                        sclk_d = 1'b1;
                    end else if (bit_q == last_bit) begin
                        scs_d  = 1'b0;
                        sclk_d = 1'b0;
                        sdi_d  = 1'b0;
                        state_d = needs_poll ? S_GAP : S_FIN;
                    end else begin
                        sclk_d  = 1'b0;
                        bit_d   = bit_q + 5'd1;
                        frame_d = {frame_q[23:0], 1'b0};
                        sdi_d   = frame_q[23];
                    end
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end

            S_GAP: begin
                if (cnt_q == TCS_C) begin
                    scs_d   = 1'b1;
                    cnt_d   = ONE_C;
                    state_d = S_POLL;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end

            S_POLL: begin
                // Ready wins over a timeout that lands on the same cycle.
                if ((cnt_q >= SDO_C) && sdo) begin
                    scs_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    state_d     = S_DONE;
                end else if (cnt_q == TMO_C) begin
                    scs_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    state_d     = S_DONE;
                end else begin
                    cnt_d = cnt_q + ONE_C;
                end
            end

            S_FIN: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = err_q;
                rsp_data_d  = ((op_q == OP_READ) && !err_q) ? rx_q : 16'h0000;
                state_d     = S_DONE;
            end

            S_DONE: begin
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end

            default: begin
                scs_d       = 1'b0;
                sclk_d      = 1'b0;
                sdi_d       = 1'b0;
                cmd_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= 3'd0;
            frame_q     <= 25'd0;
            bit_q       <= 5'd0;
            cnt_q       <= '0;
            rx_q        <= 16'h0000;
            err_q       <= 1'b0;
            cmd_ready_q <= 1'b1;
            scs_q       <= 1'b0;
            sclk_q      <= 1'b0;
            sdi_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            frame_q     <= frame_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            err_q       <= err_d;
            cmd_ready_q <= cmd_ready_d;
            scs_q       <= scs_d;
            sclk_q      <= sclk_d;
            sdi_q       <= sdi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign scs       = scs_q;
    assign sclk      = sclk_q;
    assign sdi       = sdi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_jt9346_master.sv
// tb/tb_jt9346_master.sv - self-checking bench for jt9346_master with a pin-level EEPROM model
module tb_jt9346_master;
    localparam int CLKDIV = 4, SDO_DLY = 2, TCS = 4, TMO = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [5:0] cmd_addr = 6'd0;
    logic [15:0] cmd_data = 16'd0;
    logic cmd_ready, rsp_valid, rsp_err, scs, sclk, sdi, sdo;
    logic [15:0] rsp_data;

    always #5 clk = ~clk;

    jt9346_master #(.CLKDIV(CLKDIV), .SDO_DLY(SDO_DLY), .TCS(TCS), .TMO(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .scs(scs), .sclk(sclk), .sdi(sdi), .sdo(sdo)
    );

    int n_checks = 0;
    int n_errs = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- pin-level EEPROM model ----------------
    logic [15:0] ee_mem [64];
    logic [15:0] ref_mem [64];
    bit ee_init = 0;
    bit ee_ewen = 0;
    int ee_bits = 0;
    logic [24:0] ee_sh = '0;
    logic [1:0] ee_op = 2'b00;
    logic [5:0] ee_addr = 6'd0;
    bit prev_scs = 0, prev_sclk = 0;
    int busy = 0;
    int busy_len = 50;
    bit pend_v = 0;
    logic pend_b = 1'b0;
    logic sdo_m = 1'b0;
    bit force_low = 0;
    logic cap [$];
    int pin_cnt = 0;
    int rsp_cnt = 0;

    assign sdo = force_low ? 1'b0 : sdo_m;

    task automatic ee_finish();
        if (ee_bits == 9) begin
            if (ee_op == 2'b11) begin
                if (ee_ewen) ee_mem[ee_addr] = 16'hFFFF;
                busy = busy_len;
            end else if (ee_op == 2'b00) begin
                case (ee_addr[5:4])
                    2'b11: ee_ewen = 1;
                    2'b00: ee_ewen = 0;
                    2'b10: begin
                        if (ee_ewen) for (int i = 0; i < 64; i++) ee_mem[i] = 16'hFFFF;
                        busy = busy_len;
                    end
                    default: ;
                endcase
            end
        end else if (ee_bits == 25) begin
            if (ee_op == 2'b01) begin
                if (ee_ewen) ee_mem[ee_addr] = ee_sh[15:0];
                busy = busy_len;
            end else if (ee_op == 2'b00 && ee_addr[5:4] == 2'b01) begin
                if (ee_ewen) for (int i = 0; i < 64; i++) ee_mem[i] = ee_sh[15:0];
                busy = busy_len;
            end
        end
    endtask

    // Runs on the falling clk edge: sees a rise half a cycle late and updates
    // sdo one cycle after that, as the real part does.
    always @(negedge clk) begin
        logic [15:0] w;
        if (!ee_init) begin
            for (int i = 0; i < 64; i++) ee_mem[i] = ref_mem[i];
            ee_init = 1;
        end
        if (pend_v) begin sdo_m = pend_b; pend_v = 0; end
        if (busy > 0) busy--;
        if (scs && !prev_scs) begin ee_bits = 0; cap.delete(); end
        if (!scs && prev_scs) begin ee_finish(); ee_bits = 0; sdo_m = 1'b0; pend_v = 0; end
        if (scs && sclk && !prev_sclk) begin
            ee_bits++;
            ee_sh = {ee_sh[23:0], sdi};
            cap.push_back(sdi);
            if (ee_bits == 9) begin ee_op = ee_sh[7:6]; ee_addr = ee_sh[5:0]; end
            if (ee_bits >= 10 && ee_bits <= 25 && ee_op == 2'b10) begin
                w = ee_mem[ee_addr];
                pend_v = 1;
                pend_b = w[25 - ee_bits];
            end
        end
        if (scs && ee_bits == 0) sdo_m = (busy == 0);
        prev_scs = scs;
        prev_sclk = sclk;
        if (scs || sclk || sdi) pin_cnt++;
        if (rsp_valid) rsp_cnt++;
    end

    // ---------------- command-level reference ----------------
    bit ref_ewen = 0;

    task automatic ref_apply(input logic [2:0] op, input logic [5:0] a, input logic [15:0] d,
                             output logic [15:0] exp_d, output logic exp_e);
        exp_d = 16'h0;
        exp_e = 1'b0;
        case (op)
            3'd0: exp_d = ref_mem[a];
            3'd1: if (ref_ewen) ref_mem[a] = d;
            3'd2: if (ref_ewen) ref_mem[a] = 16'hFFFF;
            3'd3: ref_ewen = 1;
            3'd4: ref_ewen = 0;
            3'd5: if (ref_ewen) for (int i = 0; i < 64; i++) ref_mem[i] = 16'hFFFF;
            3'd6: if (ref_ewen) for (int i = 0; i < 64; i++) ref_mem[i] = d;
            default: exp_e = 1'b1;
        endcase
    endtask

    // Frame is 2*CLKDIV cycles per bit; fixed-latency ops respond one cycle after it.
    function automatic int fixed_lat(input logic [2:0] op);
        case (op)
            3'd0: return 2 * CLKDIV * 25 + 1;
            3'd3, 3'd4: return 2 * CLKDIV * 9 + 1;
            3'd7: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int min_lat(input logic [2:0] op);
        int n;
        n = (op == 3'd1 || op == 3'd6) ? 25 : 9;
        return 2 * CLKDIV * n + TCS + SDO_DLY;
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [5:0] a, input logic [15:0] d,
                           output logic [15:0] rd, output logic er, output int lat, output bit got);
        int n;
        n = 0;
        rd = 16'h0;
        er = 1'b0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        lat = 0;
        got = 0;
        while (!got && lat < 20000) begin
            @(posedge clk);
            lat++;
            #1;
            if (rsp_valid) begin got = 1; rd = rsp_data; er = rsp_err; end
        end
    endtask

    typedef struct {
        logic [2:0]  op;
        logic [5:0]  addr;
        logic [15:0] data;
        logic [15:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [15:0] rd, ed;
        logic er, ee;
        int lat, pc0, rc0;
        bit got;
        logic [24:0] exp_seq, act_seq;
        logic [2:0] op;

        for (int i = 0; i < 64; i++) ref_mem[i] = 16'($urandom);
        ref_mem[5] = 16'hA55A;
        ref_mem[0] = 16'h0F0F;

        tbl[0]  = '{3'd0, 6'h05, 16'h0000, 16'hA55A, 1'b0};
        tbl[1]  = '{3'd3, 6'h00, 16'h0000, 16'h0000, 1'b0};
        tbl[2]  = '{3'd1, 6'h3F, 16'h1234, 16'h0000, 1'b0};
        tbl[3]  = '{3'd0, 6'h3F, 16'h0000, 16'h1234, 1'b0};
        tbl[4]  = '{3'd4, 6'h00, 16'h0000, 16'h0000, 1'b0};
        tbl[5]  = '{3'd1, 6'h00, 16'hBEEF, 16'h0000, 1'b0};
        tbl[6]  = '{3'd0, 6'h00, 16'h0000, 16'h0F0F, 1'b0};
        tbl[7]  = '{3'd7, 6'h11, 16'h5A5A, 16'h0000, 1'b1};
        tbl[8]  = '{3'd3, 6'h00, 16'h0000, 16'h0000, 1'b0};
        tbl[9]  = '{3'd5, 6'h00, 16'h0000, 16'h0000, 1'b0};
        tbl[10] = '{3'd0, 6'h00, 16'h0000, 16'hFFFF, 1'b0};
        tbl[11] = '{3'd0, 6'h3F, 16'h0000, 16'hFFFF, 1'b0};
        tbl[12] = '{3'd6, 6'h00, 16'hC3C3, 16'h0000, 1'b0};
        tbl[13] = '{3'd0, 6'h17, 16'h0000, 16'hC3C3, 1'b0};
        tbl[14] = '{3'd2, 6'h17, 16'h0000, 16'h0000, 1'b0};
        tbl[15] = '{3'd0, 6'h17, 16'h0000, 16'hFFFF, 1'b0};
        tbl[16] = '{3'd0, 6'h16, 16'h0000, 16'hC3C3, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_scs", scs, 0);
        chk("reset_sclk", sclk, 0);
        chk("reset_sdi", sdi, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_cmd_ready", cmd_ready, 1);
        @(negedge clk) rst_n = 1'b1;

        // READ 0x05 with frame contents and handshake timing
        run_cmd(3'd0, 6'h05, 16'h0, rd, er, lat, got);
        chk("read05_got", got, 1);
        chk("read05_data", rd, 16'hA55A);
        chk("read05_err", er, 0);
        chk("read05_lat", lat, 201);
        chk("read05_ready_low_in_rsp", cmd_ready, 0);
        chk("read05_scs_in_rsp", scs, 0);
        chk("read05_nbits", cap.size(), 25);
        exp_seq = 25'b1_10_000101_0000000000000000;
        act_seq = '0;
        for (int i = 0; i < 25 && i < cap.size(); i++) act_seq[24 - i] = cap[i];
        chk("read05_sdi_seq", act_seq, exp_seq);
        @(posedge clk); #1;
        chk("read05_rsp_one_cycle", rsp_valid, 0);
        chk("read05_ready_back", cmd_ready, 1);
        ref_apply(3'd0, 6'h05, 16'h0, ed, ee);

        // Table-driven commands
        for (int i = 0; i < 17; i++) begin
            pc0 = pin_cnt;
            busy_len = 20 + 7 * i;
            run_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, rd, er, lat, got);
            ref_apply(tbl[i].op, tbl[i].addr, tbl[i].data, ed, ee);
            chk($sformatf("tbl%0d_got", i), got, 1);
            chk($sformatf("tbl%0d_data", i), rd, tbl[i].exp_d);
            chk($sformatf("tbl%0d_err", i), er, tbl[i].exp_e);
            if (fixed_lat(tbl[i].op) != 0)
                chk($sformatf("tbl%0d_lat", i), lat, fixed_lat(tbl[i].op));
            else
                chk($sformatf("tbl%0d_lat_range", i),
                    (lat >= min_lat(tbl[i].op) && lat < min_lat(tbl[i].op) + TMO), 1);
            if (tbl[i].op == 3'd7)
                chk("reserved_no_pins", pin_cnt - pc0, 0);
        end

        // Poll timeout on ERASE
        force_low = 1;
        run_cmd(3'd2, 6'h10, 16'h0, rd, er, lat, got);
        force_low = 0;
        ref_apply(3'd2, 6'h10, 16'h0, ed, ee);
        chk("tmo_got", got, 1);
        chk("tmo_err", er, 1);
        chk("tmo_lat", lat, 2 * CLKDIV * 9 + TCS + TMO);
        chk("tmo_scs", scs, 0);
        @(posedge clk); #1;
        chk("tmo_scs_after", scs, 0);

        // Reset during bit 12 of a WRITE
        @(negedge clk);
        while (!cmd_ready) @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = 6'h2A; cmd_data = 16'h5555;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (89) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_scs", scs, 0);
        chk("rst_sclk", sclk, 0);
        chk("rst_sdi", sdi, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        rc0 = rsp_cnt;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("rst_no_rsp", rsp_cnt - rc0, 0);
        run_cmd(3'd0, 6'h2A, 16'h0, rd, er, lat, got);
        ref_apply(3'd0, 6'h2A, 16'h0, ed, ee);
        chk("rst_read_got", got, 1);
        chk("rst_read_data", rd, ed);
        chk("rst_read_lat", lat, 201);

        // Randomized commands against the reference
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            busy_len = $urandom_range(10, 200);
            cmd_addr = 6'($urandom);
            cmd_data = 16'($urandom);
            begin
                logic [5:0] a;
                logic [15:0] d;
                a = cmd_addr;
                d = cmd_data;
                run_cmd(op, a, d, rd, er, lat, got);
                ref_apply(op, a, d, ed, ee);
            end
            chk($sformatf("rnd%0d_op%0d_got", i, op), got, 1);
            chk($sformatf("rnd%0d_op%0d_data", i, op), rd, ed);
            chk($sformatf("rnd%0d_op%0d_err", i, op), er, ee);
            if (fixed_lat(op) != 0)
                chk($sformatf("rnd%0d_op%0d_lat", i, op), lat, fixed_lat(op));
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
